rx_link_sync: RTL and testbench

RX_LINK_SYNC -- requirements
Module: rx_link_sync

---
 rtl/rx_link_sync.sv | 179 +++++++++++++++++
 tb/tb_rx_link_sync.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_link_sync.sv
// Link synchronisation for an 8b/10b receiver: comma alignment with bit slips,
// sync acquisition, and credit-based loss-of-sync detection.
`timescale 1ns/1ps
module rx_link_sync #(
    parameter int unsigned SLIP_WINDOW  = 20,
    parameter int unsigned SLIP_SETTLE  = 4,
    parameter int unsigned COMMA_NEEDED = 3,
    parameter int unsigned GOOD_RUN     = 4,
    parameter int unsigned ERR_LIMIT    = 4
) (
    input  logic       BitCLK_10,
    input  logic       Reset,
    input  logic       Link_Enable,
    input  logic [9:0] RxParallel_10,
    input  logic       Decode_Error,
    input  logic       Disparity_Error,
    output logic       Sync_Status,
    output logic       BitSlip,
    output logic       Comma_Detect,
    output logic       Lock_Lost,
    output logic [7:0] Error_Count
);
    localparam int unsigned NC_W = $clog2(SLIP_WINDOW + 1);
    localparam int unsigned ST_W = $clog2(SLIP_SETTLE + 1);
    localparam int unsigned CC_W = $clog2(COMMA_NEEDED + 1);
    localparam int unsigned GR_W = $clog2(GOOD_RUN + 1);
    localparam int unsigned CR_W = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {ST_LOS, ST_SETTLE, ST_ACQ, ST_SYNC} state_t;

    state_t            state_q, state_d;
    logic [NC_W-1:0]   nocomma_q, nocomma_d;
    logic [ST_W-1:0]   settle_q, settle_d;
    logic [CC_W-1:0]   comma_q, comma_d;
    logic [GR_W-1:0]   run_q, run_d;
    logic [CR_W-1:0]   credit_q, credit_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              sync_q, sync_d;
    logic              slip_q, slip_d;
    logic              cd_q, cd_d;
    logic              lost_q, lost_d;

    logic              invalid_c;
    logic              good_comma_c;
    logic              unused_bits_c;

    // g, h and j take no part in comma detection
    assign unused_bits_c = ^RxParallel_10[9:7];

    assign invalid_c    = Decode_Error | Disparity_Error;
    assign good_comma_c = cd_q & ~invalid_c;

    always_comb begin
        state_d   = state_q;
        nocomma_d = nocomma_q;
        settle_d  = settle_q;
        comma_d   = comma_q;
        run_d     = run_q;
        credit_d  = credit_q;
        err_cnt_d = err_cnt_q;
        slip_d    = 1'b0;
        lost_d    = 1'b0;
        cd_d      = (RxParallel_10[6:0] == 7'h7C) || (RxParallel_10[6:0] == 7'h03);

        if (!Link_Enable) begin
            state_d   = ST_LOS;
            nocomma_d = '0;
            settle_d  = '0;
            comma_d   = '0;
            run_d     = '0;
            credit_d  = '0;
            lost_d    = (state_q == ST_SYNC);
        end else begin
            unique case (state_q)
                ST_LOS: begin
                    if (good_comma_c) begin
                        nocomma_d = '0;
                        comma_d   = CC_W'(1);
                        state_d   = ST_ACQ;
                    end else if (nocomma_q + NC_W'(1) >= NC_W'(SLIP_WINDOW)) begin
                        nocomma_d = '0;
                        settle_d  = '0;
                        slip_d    = 1'b1;
                        state_d   = ST_SETTLE;
                    end else begin
                        nocomma_d = nocomma_q + NC_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_q + ST_W'(1) >= ST_W'(SLIP_SETTLE)) begin
                        settle_d  = '0;
                        nocomma_d = '0;
                        state_d   = ST_LOS;
                    end else begin
                        settle_d = settle_q + ST_W'(1);
                    end
                end
                ST_ACQ: begin
                    if (invalid_c) begin
                        comma_d   = '0;
                        nocomma_d = '0;
                        state_d   = ST_LOS;
                    end else if (cd_q) begin
                        if (comma_q + CC_W'(1) >= CC_W'(COMMA_NEEDED)) begin
                            comma_d  = '0;
                            run_d    = '0;
                            credit_d = '0;
                            state_d  = ST_SYNC;
                        end else begin
                            comma_d = comma_q + CC_W'(1);
                        end
                    end
                end
                ST_SYNC: begin
                    // an invalid symbol always beats a completing good run
                    if (invalid_c) begin
                        run_d = '0;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        if (credit_q + CR_W'(1) >= CR_W'(ERR_LIMIT)) begin
                            credit_d = '0;
                            comma_d  = '0;
                            lost_d   = 1'b1;
                            state_d  = ST_LOS;
                        end else begin
                            credit_d = credit_q + CR_W'(1);
                        end
                    end else if (run_q + GR_W'(1) >= GR_W'(GOOD_RUN)) begin
                        run_d = '0;
                        if (credit_q != '0) begin
                            credit_d = credit_q - CR_W'(1);
                        end
                    end else begin
                        run_d = run_q + GR_W'(1);
                    end
                end
                default: state_d = ST_LOS;
            endcase
        end

        sync_d = (state_d == ST_SYNC);
    end

    always_ff @(posedge BitCLK_10 or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_LOS;
            nocomma_q <= '0;
            settle_q  <= '0;
            comma_q   <= '0;
            run_q     <= '0;
            credit_q  <= '0;
            err_cnt_q <= '0;
            sync_q    <= 1'b0;
            slip_q    <= 1'b0;
            cd_q      <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            nocomma_q <= nocomma_d;
            settle_q  <= settle_d;
            comma_q   <= comma_d;
            run_q     <= run_d;
            credit_q  <= credit_d;
            err_cnt_q <= err_cnt_d;
            sync_q    <= sync_d;
            slip_q    <= slip_d;
            cd_q      <= cd_d;
            lost_q    <= lost_d;
        end
    end

    assign Sync_Status  = sync_q;
    assign BitSlip      = slip_q;
    assign Comma_Detect = cd_q;
    assign Lock_Lost    = lost_q;
    assign Error_Count  = err_cnt_q;

endmodule

// File: tb/tb_rx_link_sync.sv
// Directed bench for rx_link_sync: vector table plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_rx_link_sync;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [9:0] rx = 10'h2AA;
    logic       de = 1'b0;
    logic       pe = 1'b0;
    logic       sync_s, slip_s, cd_s, lost_s;
    logic [7:0] ec_s;

    int checks = 0;
    int failures = 0;

    localparam logic [9:0] KN = 10'h17C;  // K28.5, RD-
    localparam logic [9:0] KP = 10'h283;  // K28.5, RD+
    localparam logic [9:0] DD = 10'h2AA;  // plain data symbol, no comma

    rx_link_sync dut (
        .BitCLK_10      (clk),
        .Reset          (rst),
        .Link_Enable    (en),
        .RxParallel_10  (rx),
        .Decode_Error   (de),
        .Disparity_Error(pe),
        .Sync_Status    (sync_s),
        .BitSlip        (slip_s),
        .Comma_Detect   (cd_s),
        .Lock_Lost      (lost_s),
        .Error_Count    (ec_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] rx;
        logic       de;
        logic       pe;
        logic       en;
        logic       sync;
        logic       slip;
        logic       cd;
        logic       lost;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(logic [9:0] r, logic d, logic p, logic e,
                                logic s, logic sl, logic c, logic l, logic [7:0] n);
        vec_t v;
        v.rx = r; v.de = d; v.pe = p; v.en = e;
        v.sync = s; v.slip = sl; v.cd = c; v.lost = l; v.ec = n;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [9:0] r, input logic d, input logic p);
        rx = r; de = d; pe = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; rx = DD; de = 1'b0; pe = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic sync_up();
        step(KN, 1'b0, 1'b0);
        step(KP, 1'b0, 1'b0);
        step(KN, 1'b0, 1'b0);
        chk("sync_before_third", 32'(sync_s), 32'd0);
        step(DD, 1'b0, 1'b0);
        chk("sync_up", 32'(sync_s), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(KN, 0, 0, 1,  0, 0, 1, 0, 8'd0);
        tbl[1]  = mk(KP, 0, 0, 1,  0, 0, 1, 0, 8'd0);
        tbl[2]  = mk(KN, 0, 0, 1,  0, 0, 1, 0, 8'd0);
        tbl[3]  = mk(DD, 0, 0, 1,  1, 0, 0, 0, 8'd0);
        tbl[4]  = mk(DD, 1, 0, 1,  1, 0, 0, 0, 8'd1);
        tbl[5]  = mk(DD, 0, 0, 1,  1, 0, 0, 0, 8'd1);
        tbl[6]  = mk(DD, 0, 0, 1,  1, 0, 0, 0, 8'd1);
        tbl[7]  = mk(DD, 1, 0, 1,  1, 0, 0, 0, 8'd2);
        tbl[8]  = mk(DD, 0, 0, 1,  1, 0, 0, 0, 8'd2);
        tbl[9]  = mk(DD, 0, 0, 1,  1, 0, 0, 0, 8'd2);
        tbl[10] = mk(DD, 0, 1, 1,  1, 0, 0, 0, 8'd3);
        tbl[11] = mk(DD, 0, 0, 1,  1, 0, 0, 0, 8'd3);
        tbl[12] = mk(DD, 0, 0, 1,  1, 0, 0, 0, 8'd3);
        tbl[13] = mk(DD, 1, 0, 1,  0, 0, 0, 1, 8'd4);
        tbl[14] = mk(DD, 0, 0, 1,  0, 0, 0, 0, 8'd4);
        tbl[15] = mk(KN, 0, 0, 1,  0, 0, 1, 0, 8'd4);
        tbl[16] = mk(KP, 0, 0, 1,  0, 0, 1, 0, 8'd4);
        tbl[17] = mk(DD, 1, 0, 1,  0, 0, 0, 0, 8'd4);
        tbl[18] = mk(KN, 0, 0, 1,  0, 0, 1, 0, 8'd4);
        tbl[19] = mk(KN, 0, 0, 1,  0, 0, 1, 0, 8'd4);
        tbl[20] = mk(KN, 0, 0, 1,  0, 0, 1, 0, 8'd4);
        tbl[21] = mk(DD, 0, 0, 1,  1, 0, 0, 0, 8'd4);
        tbl[22] = mk(DD, 0, 0, 1,  1, 0, 0, 0, 8'd4);
        tbl[23] = mk(DD, 0, 0, 0,  0, 0, 0, 1, 8'd4);
        tbl[24] = mk(KN, 0, 0, 0,  0, 0, 1, 0, 8'd4);
        tbl[25] = mk(KN, 0, 0, 0,  0, 0, 1, 0, 8'd4);
        tbl[26] = mk(KN, 0, 0, 0,  0, 0, 1, 0, 8'd4);

        // reset state while Reset is held
        #12;
        chk("rst_sync", 32'(sync_s), 32'd0);
        chk("rst_slip", 32'(slip_s), 32'd0);
        chk("rst_cd",   32'(cd_s),   32'd0);
        chk("rst_lost", 32'(lost_s), 32'd0);
        chk("rst_ec",   32'(ec_s),   32'd0);
        do_reset();

        // acquisition, error credit loss, ACQ abort, Link_Enable drop
        for (int i = 0; i < 27; i++) begin
            en = tbl[i].en;
            step(tbl[i].rx, tbl[i].de, tbl[i].pe);
            chk($sformatf("v%0d_sync", i), 32'(sync_s), 32'(tbl[i].sync));
            chk($sformatf("v%0d_slip", i), 32'(slip_s), 32'(tbl[i].slip));
            chk($sformatf("v%0d_cd",   i), 32'(cd_s),   32'(tbl[i].cd));
            chk($sformatf("v%0d_lost", i), 32'(lost_s), 32'(tbl[i].lost));
            chk($sformatf("v%0d_ec",   i), 32'(ec_s),   32'(tbl[i].ec));
        end

        // slip window, settle ignoring commas, restart of counting
        do_reset();
        for (int i = 1; i <= 50; i++) begin
            step((i == 21 || i == 22) ? KN : DD, 1'b0, 1'b0);
            chk($sformatf("slip_c%0d", i), 32'(slip_s), 32'((i == 20) || (i == 44)));
        end
        chk("slip_no_sync", 32'(sync_s), 32'd0);

        // no slips while disabled
        en = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step(DD, 1'b0, 1'b0);
            chk($sformatf("dis_slip_c%0d", i), 32'(slip_s), 32'd0);
        end
        en = 1'b1;

        // reset truncates a BitSlip pulse, then counting restarts from zero
        do_reset();
        repeat (20) step(DD, 1'b0, 1'b0);
        chk("pre_rst_slip", 32'(slip_s), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_slip", 32'(slip_s), 32'd0);
        #2 rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step(DD, 1'b0, 1'b0);
            chk($sformatf("post_rst_slip_c%0d", i), 32'(slip_s), 32'(i == 20));
        end

        // credit retire: 3 errors, 12 good, 3 errors holds sync
        do_reset();
        sync_up();
        repeat (3) step(DD, 1'b1, 1'b0);
        chk("cr_sync_a", 32'(sync_s), 32'd1);
        repeat (12) step(DD, 1'b0, 1'b0);
        repeat (3) step(DD, 1'b0, 1'b1);
        chk("cr_sync_b", 32'(sync_s), 32'd1);
        chk("cr_lost_b", 32'(lost_s), 32'd0);
        chk("cr_ec_b",   32'(ec_s),   32'd6);
        // incomplete good run does not retire credit
        repeat (3) step(DD, 1'b0, 1'b0);
        step(DD, 1'b1, 1'b0);
        chk("cr_lost_c", 32'(lost_s), 32'd1);
        chk("cr_sync_c", 32'(sync_s), 32'd0);
        chk("cr_ec_c",   32'(ec_s),   32'd7);
        step(DD, 1'b0, 1'b0);
        chk("cr_lost_d", 32'(lost_s), 32'd0);

        // Error_Count saturation over 300 errors, then Link_Enable drop in SYNC
        do_reset();
        sync_up();
        for (int r = 0; r < 100; r++) begin
            repeat (3) step(DD, 1'b1, 1'b0);
            repeat (12) step(DD, 1'b0, 1'b0);
            if (r == 49) chk("sat_ec_mid", 32'(ec_s), 32'd150);
        end
        chk("sat_ec",   32'(ec_s),   32'd255);
        chk("sat_sync", 32'(sync_s), 32'd1);
        en = 1'b0;
        step(DD, 1'b0, 1'b0);
        chk("en_sync", 32'(sync_s), 32'd0);
        chk("en_lost", 32'(lost_s), 32'd1);
        chk("en_ec",   32'(ec_s),   32'd255);
        step(DD, 1'b0, 1'b0);
        chk("en_lost_one", 32'(lost_s), 32'd0);
        en = 1'b1;

        // reset in ACQ after two commas: three fresh commas needed
        do_reset();
        step(KN, 1'b0, 1'b0);
        step(KP, 1'b0, 1'b0);
        step(KN, 1'b0, 1'b0);
        chk("acq_cd", 32'(cd_s), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("acq_rst_cd",   32'(cd_s),   32'd0);
        chk("acq_rst_sync", 32'(sync_s), 32'd0);
        chk("acq_rst_ec",   32'(ec_s),   32'd0);
        #2 rst = 1'b0;
        step(KN, 1'b0, 1'b0);
        chk("fresh_a", 32'(sync_s), 32'd0);
        step(KN, 1'b0, 1'b0);
        chk("fresh_b", 32'(sync_s), 32'd0);
        step(DD, 1'b0, 1'b0);
        chk("fresh_c", 32'(sync_s), 32'd0);
        step(DD, 1'b0, 1'b0);
        chk("fresh_d", 32'(sync_s), 32'd0);
        step(KP, 1'b0, 1'b0);
        chk("fresh_e", 32'(sync_s), 32'd0);
        step(DD, 1'b0, 1'b0);
        chk("fresh_sync", 32'(sync_s), 32'd1);
        chk("fresh_slip", 32'(slip_s), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
